execute_fwd_stage: RTL

- Parametrised ID/EX pipeline register plus execute datapath for the pipelined core.
- Adds NUM_FWD-source operand forwarding at the ALU inputs and a stall-capable busy handshake.
- Optionally adds an iterative multi-cycle multiplier.
- Sits between decode and the EX/MEM latch. The ALU result is combinational from latched state, so the EX/MEM latch captures it on the next edge.

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/alu_if.sv | 13 +
 rtl/execute_fwd_stage_if.sv | 49 ++++
 rtl/alu.sv | 31 +++
 rtl/ex_mul_iter.sv | 50 +++++
 rtl/execute_fwd_stage.sv | 154 +++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register aliases, ALU opcodes, ALU source
// select and execute-stage multiplier states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Encoding 3 is reserved and treated as ALUSRC_RT by the execute stage.
    typedef enum logic [1:0] {
        ALUSRC_RT    = 2'd0,
        ALUSRC_IMM   = 2'd1,
        ALUSRC_SHAMT = 2'd2
    } alusrc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulstate_t;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between a datapath stage and the shared ALU.
interface alu_if import cpu_types_pkg::*; #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] porta;
    logic [WORD_W-1:0] portb;
    aluop_t            aluop;
    logic [WORD_W-1:0] outport;
    logic              zero;

    modport alu  (input porta, portb, aluop, output outport, zero);
    modport user (output porta, portb, aluop, input outport, zero);
endinterface

// File: rtl/execute_fwd_stage_if.sv
// Decode-to-execute bundle: ID/EX inputs, forwarding sources, latched outputs
// and the execute-stage stall request.
interface execute_fwd_stage_if import cpu_types_pkg::*; #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_FWD = 2
);
    logic                      flush;
    logic                      exen;
    logic [WORD_W-1:0]         in_npc;
    logic [WORD_W-1:0]         in_rdat1;
    logic [WORD_W-1:0]         in_rdat2;
    logic [WORD_W-1:0]         in_imm;
    logic [WORD_W-1:0]         in_shamt;
    logic [REG_AW-1:0]         in_rs;
    logic [REG_AW-1:0]         in_rt;
    logic [REG_AW-1:0]         in_regdst;
    logic [1:0]                in_alusrc;
    aluop_t                    in_aluop;
    logic                      in_regwr, in_dren, in_dwen, in_halt, in_lui, in_mul;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD*REG_AW-1:0] fwd_addr;
    logic [NUM_FWD*WORD_W-1:0] fwd_data;
    logic [WORD_W-1:0]         out_npc;
    logic [REG_AW-1:0]         out_regdst;
    logic                      out_regwr, out_dren, out_dwen, out_halt, out_lui;
    logic [WORD_W-1:0]         out_store;
    logic [WORD_W-1:0]         out_alu;
    logic                      out_zero;
    logic                      ex_busy;

    modport master (
        output flush, exen, in_npc, in_rdat1, in_rdat2, in_imm, in_shamt,
               in_rs, in_rt, in_regdst, in_alusrc, in_aluop,
               in_regwr, in_dren, in_dwen, in_halt, in_lui, in_mul,
               fwd_valid, fwd_addr, fwd_data,
        input  out_npc, out_regdst, out_regwr, out_dren, out_dwen, out_halt,
               out_lui, out_store, out_alu, out_zero, ex_busy
    );

    modport slave (
        input  flush, exen, in_npc, in_rdat1, in_rdat2, in_imm, in_shamt,
               in_rs, in_rt, in_regdst, in_alusrc, in_aluop,
               in_regwr, in_dren, in_dwen, in_halt, in_lui, in_mul,
               fwd_valid, fwd_addr, fwd_data,
        output out_npc, out_regdst, out_regwr, out_dren, out_dwen, out_halt,
               out_lui, out_store, out_alu, out_zero, ex_busy
    );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU; shifts move porta by the low bits of portb.
module alu import cpu_types_pkg::*; #(
    parameter int unsigned WORD_W = 32
) (
    alu_if.alu aif
);
    localparam int unsigned SHW = $clog2(WORD_W);

    logic [SHW-1:0] sh;

    always_comb begin
        sh          = aif.portb[SHW-1:0];
        aif.outport = '0;
        case (aif.aluop)
            ALU_SLL:  aif.outport = aif.porta << sh;
            ALU_SRL:  aif.outport = aif.porta >> sh;
            ALU_ADD:  aif.outport = aif.porta + aif.portb;
            ALU_SUB:  aif.outport = aif.porta - aif.portb;
            ALU_AND:  aif.outport = aif.porta & aif.portb;
            ALU_OR:   aif.outport = aif.porta | aif.portb;
            ALU_XOR:  aif.outport = aif.porta ^ aif.portb;
            ALU_NOR:  aif.outport = ~(aif.porta | aif.portb);
            ALU_SLT:  aif.outport = {{(WORD_W-1){1'b0}}, $signed(aif.porta) < $signed(aif.portb)};
            ALU_SLTU: aif.outport = {{(WORD_W-1){1'b0}}, aif.porta < aif.portb};
            default:  aif.outport = '0;
        endcase
    end

    assign aif.zero = (aif.outport == '0);

endmodule

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WORD_W steps,
// low WORD_W bits of the product kept.
module ex_mul_iter #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              clear,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] product
);
    localparam int unsigned CW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] mcand, mplier, acc;
    logic [CW-1:0]     cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (clear) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WORD_W);
        end else if (cnt != '0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    assign busy    = (cnt != '0);
    // High during the final step, so the product is complete after this edge.
    assign done    = (cnt == CW'(1));
    assign product = acc;

endmodule

// File: rtl/execute_fwd_stage.sv
// ID/EX register with NUM_FWD-source operand forwarding and ALU; defining
// EX_MUL_EN adds the stalling iterative multiplier (ex_busy tied 0 otherwise).
module execute_fwd_stage import cpu_types_pkg::*; #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_FWD = 2
) (
    input logic                CLK,
    input logic                nRST,
    execute_fwd_stage_if.slave exif
);
    typedef struct packed {
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] rdat1;
        logic [WORD_W-1:0] rdat2;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] shamt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] regdst;
        logic [1:0]        alusrc;
        aluop_t            aluop;
        logic              regwr, dren, dwen, halt, lui, mul;
    } idex_t;

    idex_t             q;
    logic              ex_busy;
    logic [WORD_W-1:0] opa, rt_fwd, opb, result;
    logic              hit_a, hit_b, result_zero;

    // All-zero state is the bubble, and aluop 0 is ALU_SLL.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (exif.flush) begin
            q <= '0;
        end else if (exif.exen && !ex_busy) begin
            q <= '{npc: exif.in_npc, rdat1: exif.in_rdat1, rdat2: exif.in_rdat2,
                   imm: exif.in_imm, shamt: exif.in_shamt, rs: exif.in_rs,
                   rt: exif.in_rt, regdst: exif.in_regdst, alusrc: exif.in_alusrc,
                   aluop: exif.in_aluop, regwr: exif.in_regwr, dren: exif.in_dren,
                   dwen: exif.in_dwen, halt: exif.in_halt, lui: exif.in_lui,
                   mul: exif.in_mul};
        end
    end

    // Lowest-index matching source wins; register 0 is never forwarded.
    always_comb begin
        opa    = q.rdat1;
        rt_fwd = q.rdat2;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit_a && exif.fwd_valid[i] && (q.rs != '0) &&
                (exif.fwd_addr[i*REG_AW +: REG_AW] == q.rs)) begin
                opa   = exif.fwd_data[i*WORD_W +: WORD_W];
                hit_a = 1'b1;
            end
            if (!hit_b && exif.fwd_valid[i] && (q.rt != '0) &&
                (exif.fwd_addr[i*REG_AW +: REG_AW] == q.rt)) begin
                rt_fwd = exif.fwd_data[i*WORD_W +: WORD_W];
                hit_b  = 1'b1;
            end
        end
    end

    always_comb begin
        opb = rt_fwd;
        case (q.alusrc)
            ALUSRC_IMM:   opb = q.imm;
            ALUSRC_SHAMT: opb = q.shamt;
            default:      opb = rt_fwd;
        endcase
    end

    alu_if #(.WORD_W(WORD_W)) aluif ();

    assign aluif.porta = opa;
    assign aluif.portb = opb;
    assign aluif.aluop = q.aluop;

    alu #(.WORD_W(WORD_W)) u_alu (.aif(aluif));

`ifdef EX_MUL_EN
    mulstate_t         state, state_n;
    logic              mul_start, mul_busy, mul_done;
    logic [WORD_W-1:0] mul_prod;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // A latched mul in IDLE has not started yet: stall and launch it.
    always_comb begin
        state_n   = state;
        mul_start = 1'b0;
        ex_busy   = 1'b0;
        case (state)
            IDLE: begin
                if (q.mul) begin
                    ex_busy   = 1'b1;
                    mul_start = !exif.flush;
                    if (!exif.flush) state_n = RUN;
                end
            end
            RUN: begin
                ex_busy = 1'b1;
                if (exif.flush)                 state_n = IDLE;
                else if (mul_done || !mul_busy) state_n = DONE;
            end
            DONE: begin
                if (exif.flush || exif.exen) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    ex_mul_iter #(.WORD_W(WORD_W)) u_mul (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (exif.flush),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign result      = q.mul ? mul_prod : aluif.outport;
    assign result_zero = q.mul ? (mul_prod == '0) : aluif.zero;
`else
    logic mul_unused;

    assign mul_unused  = q.mul;
    assign ex_busy     = 1'b0;
    assign result      = aluif.outport;
    assign result_zero = aluif.zero;
`endif

    assign exif.out_npc    = q.npc;
    assign exif.out_regdst = q.regdst;
    assign exif.out_regwr  = q.regwr;
    assign exif.out_dren   = q.dren;
    assign exif.out_dwen   = q.dwen;
    assign exif.out_halt   = q.halt;
    assign exif.out_lui    = q.lui;
    assign exif.out_store  = rt_fwd;
    assign exif.out_alu    = result;
    assign exif.out_zero   = result_zero;
    assign exif.ex_busy    = ex_busy;

endmodule
